// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns a raw, bouncy, asynchronous push-button into a clean debounced level
// and classifies each gesture as a short, double or long press. Every
// classified gesture produces a one-cycle event with a 2-bit code and steps a
// wrap-around mode index that the LED pattern blocks consume directly.
module button_event_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 250_000,
    parameter int unsigned LONG_CYCLES     = 25_000_000,
    parameter int unsigned GAP_CYCLES      = 7_500_000,
    parameter int unsigned MODE_COUNT      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       btn_level,
    output logic       event_valid,
    output logic [1:0] event_code,
    output logic [2:0] mode
);

    // Counter widths. The gesture timer has one spare bit so that it can sit
    // at its saturation value well above every threshold it is compared with.
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned TMR_W = $clog2(LONG_CYCLES) + 1;

    // Thresholds are compared against the value a counter holds *before* the
    // edge, so "reached N" means the count currently reads N-1.
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX   = '1;
    localparam logic [2:0]       MODE_LAST = 3'(MODE_COUNT - 1);

    // Event codes presented on event_code.
    localparam logic [1:0] CODE_NONE   = 2'b00;
    localparam logic [1:0] CODE_SHORT  = 2'b01;
    localparam logic [1:0] CODE_DOUBLE = 2'b10;
    localparam logic [1:0] CODE_LONG   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        PRESS2,
        HOLD
    } state_t;

    logic              sync_meta;
    logic              sync_btn;
    logic [DB_W-1:0]   db_count;
    logic              db_toggle;
    logic              level_rise;
    logic              level_fall;
    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_inc;
    logic [2:0]        mode_up;
    logic [2:0]        mode_down;

    // Two-flop synchroniser bringing the asynchronous button into clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_btn  <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_btn  <= sync_meta;
        end
    end

    // The debouncer flips the level on the same edge the stable count is
    // reached; the classifier uses this strobe so it reacts on that edge too.
    assign db_toggle  = (sync_btn != btn_level) && (db_count == DB_LAST);
    assign level_rise = db_toggle && !btn_level;
    assign level_fall = db_toggle &&  btn_level;

    // Debouncer: accept a new level only after it has been stable long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_count  <= '0;
            btn_level <= 1'b0;
        end else if (sync_btn == btn_level) begin
            db_count  <= '0;
        end else if (db_toggle) begin
            db_count  <= '0;
            btn_level <= ~btn_level;
        end else begin
            db_count  <= db_count + 1'b1;
        end
    end

    // Saturating increment: the timer parks at its maximum instead of
    // wrapping, so a very long hold can never look short again.
    assign timer_inc = (timer == TMR_MAX) ? timer : timer + 1'b1;

    // Wrap-around neighbours of the current mode.
    assign mode_up   = (mode == MODE_LAST) ? 3'd0 : mode + 3'd1;
    assign mode_down = (mode == 3'd0) ? MODE_LAST : mode - 3'd1;

    // Gesture classifier with registered event outputs and mode index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            event_valid <= 1'b0;
            event_code  <= CODE_NONE;
            mode        <= 3'd0;
        end else begin
            event_valid <= 1'b0;
            event_code  <= CODE_NONE;
            case (state)
                IDLE: begin
                    if (level_rise) begin
                        state <= PRESS1;
                        timer <= '0;
                    end
                end
                PRESS1: begin
                    // The long threshold is checked first: a release landing on
                    // the very edge the hold reaches LONG_CYCLES still counts as
                    // long, and the FSM then skips HOLD since the button is gone.
                    if (timer == LONG_LAST) begin
                        event_valid <= 1'b1;
                        event_code  <= CODE_LONG;
                        mode        <= 3'd0;
                        timer       <= timer_inc;
                        state       <= level_fall ? IDLE : HOLD;
                    end else if (level_fall) begin
                        state <= GAP;
                        timer <= '0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                GAP: begin
                    // Expiry beats a simultaneous new press; that press is kept
                    // by going straight to PRESS1 with a fresh timer.
                    if (timer == GAP_LAST) begin
                        event_valid <= 1'b1;
                        event_code  <= CODE_SHORT;
                        mode        <= mode_up;
                        timer       <= '0;
                        state       <= level_rise ? PRESS1 : IDLE;
                    end else if (level_rise) begin
                        state <= PRESS2;
                        timer <= '0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                PRESS2: begin
                    // The second press length is irrelevant; only its release
                    // matters, so it can never turn into a long press.
                    if (level_fall) begin
                        event_valid <= 1'b1;
                        event_code  <= CODE_DOUBLE;
                        mode        <= mode_down;
                        state       <= IDLE;
                    end
                end
                HOLD: begin
                    if (level_fall) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder
// Drives button waveforms built from segments of constant level. A reference
// model turns the segment list into debounced press intervals and classifies
// them; expected events are queued and a negedge monitor compares them as the
// decoder emits them.
module tb_button_event_decoder;

    localparam int DEB     = 4;
    localparam int LONG    = 40;
    localparam int GAP_LEN = 20;
    localparam int MODES   = 5;

    typedef struct {
        logic lvl;
        int   len;
    } seg_t;

    typedef struct {
        logic [1:0] code;
        int         edge_no;
        int         mode_after;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       btn_level;
    logic       event_valid;
    logic [1:0] event_code;
    logic [2:0] mode;

    seg_t seg_q[$];
    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   mdl_mode = 0;
    int   mon_mode = 0;

    button_event_decoder #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LONG),
        .GAP_CYCLES(GAP_LEN),
        .MODE_COUNT(MODES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .btn_level(btn_level),
        .event_valid(event_valid),
        .event_code(event_code),
        .mode(mode)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    // Absolute count of rising edges, used to time-stamp events.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic addSeg(input logic lvl, input int len);
        seg_t s;
        s.lvl = lvl;
        s.len = len;
        seg_q.push_back(s);
    endtask

    task automatic pushEvent(input logic [1:0] code, input int edge_no);
        exp_t e;
        case (code)
            2'b01:   mdl_mode = (mdl_mode + 1) % MODES;
            2'b10:   mdl_mode = (mdl_mode + MODES - 1) % MODES;
            default: mdl_mode = 0;
        endcase
        e.code       = code;
        e.edge_no    = edge_no;
        e.mode_after = mdl_mode;
        exp_q.push_back(e);
    endtask

    // Model the segment list, queue the expected events, then drive it while
    // checking the debounced level every cycle.
    task automatic applyStimulus();
        int   rises[$];
        int   falls[$];
        logic drv[$];
        int   n0;
        int   nk;
        int   i;
        logic exp_lvl;
        @(posedge clk);
        #1;
        n0 = cyc;
        nk = n0;
        // A clean segment of at least DEB cycles reappears on btn_level
        // 2+DEB edges later with the same length; shorter highs vanish.
        foreach (seg_q[k]) begin
            if (seg_q[k].lvl && seg_q[k].len >= DEB) begin
                rises.push_back(nk + 2 + DEB);
                falls.push_back(nk + seg_q[k].len + 2 + DEB);
            end
            for (int j = 0; j < seg_q[k].len; j++) drv.push_back(seg_q[k].lvl);
            nk += seg_q[k].len;
        end
        i = 0;
        while (i < rises.size()) begin
            if (falls[i] - rises[i] >= LONG) begin
                pushEvent(2'b11, rises[i] + LONG);
                i++;
            end else if (i + 1 < rises.size() && rises[i+1] - falls[i] < GAP_LEN) begin
                pushEvent(2'b10, falls[i+1]);
                i += 2;
            end else begin
                pushEvent(2'b01, falls[i] + GAP_LEN);
                i++;
            end
        end
        foreach (drv[x]) begin
            btn = drv[x];
            exp_lvl = 1'b0;
            foreach (rises[r]) begin
                if (n0 + x >= rises[r] && n0 + x < falls[r]) exp_lvl = 1'b1;
            end
            checkOutput("btn_level", btn_level, exp_lvl);
            @(posedge clk);
            #1;
        end
        checkOutput("pending_events", exp_q.size(), 0);
    endtask

    // Scoreboard monitor: pops an expectation whenever an event appears.
    always @(negedge clk) begin
        if (rst) begin
            mon_mode = 0;
        end else if (event_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_event", event_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("event_code", event_code, mon_e.code);
                checkOutput("event_cycle", cyc, mon_e.edge_no);
                checkOutput("event_mode", mode, mon_e.mode_after);
                mon_mode = mon_e.mode_after;
            end
        end else begin
            checkOutput("idle_code", event_code, 0);
            checkOutput("mode_hold", mode, mon_mode);
        end
    end

    initial begin
        int r;
        int hl;
        int ll;
        bit glitch;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_btn_level", btn_level, 0);
        checkOutput("reset_event_valid", event_valid, 0);
        checkOutput("reset_event_code", event_code, 0);
        checkOutput("reset_mode", mode, 0);
        rst = 1'b0;

        // Glitch shorter than the debounce window.
        seg_q.delete(); addSeg(0, 30); addSeg(1, 3); addSeg(0, 40);
        applyStimulus();
        // Single short press.
        seg_q.delete(); addSeg(0, 30); addSeg(1, 12); addSeg(0, 40);
        applyStimulus();
        // Double press, then second rise exactly on gap expiry.
        seg_q.delete(); addSeg(0, 30); addSeg(1, 12); addSeg(0, 8); addSeg(1, 12); addSeg(0, 40);
        applyStimulus();
        seg_q.delete(); addSeg(0, 30); addSeg(1, 12); addSeg(0, GAP_LEN); addSeg(1, 12); addSeg(0, 40);
        applyStimulus();
        // Long hold, then a hold one cycle short of long.
        seg_q.delete(); addSeg(0, 30); addSeg(1, 60); addSeg(0, 40); addSeg(1, LONG - 1); addSeg(0, 40);
        applyStimulus();
        // Five shorts walking the mode round, then one double.
        seg_q.delete(); addSeg(0, 30);
        for (int k = 0; k < 5; k++) begin
            addSeg(1, 12); addSeg(0, 28);
        end
        addSeg(0, 12);
        addSeg(1, 12); addSeg(0, 8); addSeg(1, 70); addSeg(0, 40);
        applyStimulus();

        // Randomised gesture mixes including the boundary lengths.
        for (int b = 0; b < 12; b++) begin
            seg_q.delete();
            addSeg(0, 30);
            for (int g = 0; g < 6; g++) begin
                glitch = 1'b0;
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    hl = $urandom_range(1, DEB - 1);
                    glitch = 1'b1;
                end else if (r == 1) hl = LONG - 1;
                else if (r <= 3) hl = $urandom_range(LONG + 1, LONG + 25);
                else hl = $urandom_range(DEB, LONG - 2);
                r = $urandom_range(0, 9);
                if (glitch) ll = GAP_LEN + 5;
                else if (r <= 3) ll = $urandom_range(DEB, GAP_LEN - 1);
                else if (r == 4) ll = GAP_LEN;
                else if (r == 5) ll = GAP_LEN - 1;
                else ll = $urandom_range(GAP_LEN + 1, GAP_LEN + 15);
                addSeg(1, hl);
                addSeg(0, ll);
            end
            addSeg(0, 40);
            applyStimulus();
        end

        // Make sure the mode is non-zero so the reset check means something.
        if (mdl_mode == 0) begin
            seg_q.delete(); addSeg(0, 30); addSeg(1, 12); addSeg(0, 40);
            applyStimulus();
        end

        // Reset in the middle of a hold, button released while in reset.
        @(posedge clk);
        #1;
        btn = 1'b1;
        repeat (2 + DEB + 20) @(posedge clk);
        #1;
        checkOutput("hold_level", btn_level, 1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_btn_level", btn_level, 0);
        checkOutput("rst_event_valid", event_valid, 0);
        checkOutput("rst_event_code", event_code, 0);
        checkOutput("rst_mode", mode, 0);
        btn = 1'b0;
        mdl_mode = 0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        seg_q.delete(); addSeg(0, 80);
        applyStimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Front-end input decoder for the board's push-button mode controllers. It synchronises and debounces a raw mechanical button and classifies each gesture as a short press, double press or long press. For each classified gesture it emits a one-cycle event with a 2-bit code. It also maintains a wrap-around mode index that downstream LED pattern blocks consume directly.

## Interface
- `DEBOUNCE_CYCLES`, default 250_000 (10 ms @ 25 MHz): consecutive stable cycles required to accept a level change; ≥1.
- `LONG_CYCLES`, default 25_000_000 (1 s): hold time that classifies a long press; must exceed `GAP_CYCLES`.
- `GAP_CYCLES`, default 7_500_000 (300 ms): maximum release-to-press gap for a double press; ≥2.
- `MODE_COUNT`, default 5: number of modes, range 2..8.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `btn` input 1: raw button, active-high, asynchronous to `clk`.
- `btn_level` output 1: debounced button level.
- `event_valid` output 1: one-cycle pulse when a gesture is classified.
- `event_code` output 2: 01 short, 10 double, 11 long, 00 none; valid when `event_valid`=1.
- `mode` output 3: current mode index, 0..`MODE_COUNT`-1.

## Operation
- **Reset:** `rst` asynchronously clears everything. `btn_level`=0, `event_valid`=0, `event_code`=00, `mode`=0, FSM=IDLE, all timers 0, synchroniser flops 0.
- **Synchroniser:** 2-flop synchroniser on `btn`.
- **Debouncer:** a counter increments while the synchronised value differs from `btn_level` and clears when they match. When it reaches `DEBOUNCE_CYCLES`, `btn_level` toggles and the counter clears. Pulses shorter than `DEBOUNCE_CYCLES` cycles never reach `btn_level`.
- **Classifier FSM:** driven only by `btn_level` edges and a shared timer sized `$clog2(LONG_CYCLES)+1` bits. The timer saturates and never wraps.
  - IDLE: on `btn_level` rise, go to PRESS1 and clear the timer.
  - PRESS1: timer counts. If the hold reaches `LONG_CYCLES`, emit LONG and go to HOLD. On fall, go to GAP and clear the timer.
  - GAP: timer counts. On rise before expiry, go to PRESS2. On expiry (`GAP_CYCLES`), emit SHORT and go to IDLE.
  - PRESS2: on fall, emit DOUBLE and go to IDLE. The length of the second press is ignored.
  - HOLD: on fall, go to IDLE; no event.
- **Mode update:** on the same edge that asserts `event_valid`:
  - SHORT: `mode`+1, wrapping `MODE_COUNT`-1 → 0.
  - DOUBLE: `mode`-1, wrapping 0 → `MODE_COUNT`-1.
  - LONG: `mode`=0.
- **Event outputs:** `event_code` holds its value only while `event_valid`=1 and returns to 00 otherwise. At most one event per cycle.

## Timing
- `btn` edge to `btn_level` edge: 2 + `DEBOUNCE_CYCLES` clock edges, for a clean input.
- Let E = the edge where `btn_level` rises and F = the edge where it falls.
- LONG: `event_valid` high in the cycle following edge E+`LONG_CYCLES`, provided `btn_level` is still high.
- SHORT: `event_valid` high in the cycle following edge F+`GAP_CYCLES`.
- DOUBLE: `event_valid` high in the cycle following the second F edge.
- `mode` is registered and changes at the same edge that raises `event_valid`.
- Boundary conditions:
  - Gap expiry and a new rise on the same edge: expiry wins. SHORT is emitted and the FSM enters PRESS1 directly, so the new press is kept.
  - Hold reaching exactly `LONG_CYCLES`-1 then releasing: not long. The FSM goes to GAP.
  - Second press held beyond `LONG_CYCLES`: still DOUBLE on release, never LONG.
  - Reset mid-gesture: gesture discarded. If the button is held through reset release, it is treated as a new press after debounce.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=40, `GAP_CYCLES`=20, `MODE_COUNT`=5.
1. Reset, then 3-cycle `btn` glitch → `btn_level` stays 0, no `event_valid`, `mode`=0.
2. `btn` high 12 cycles then low → exactly one pulse, code 01, at F+20; `mode` 0→1.
3. Two 12-cycle presses with an 8-cycle gap → one pulse, code 10, one cycle after second fall; `mode` 0→4. Repeat with the second rise landing exactly on gap expiry → code 01 and a new press tracked.
4. Hold 60 cycles → code 11 at E+40, `mode` → 0, no event on release. Hold for a `btn_level` duration of 39 → code 01 after the gap.
5. Five short presses spaced 40 cycles → `mode` sequence 1, 2, 3, 4, 0. One double from 0 → 4.
6. Assert `rst` 20 cycles into a hold → all outputs 0 asynchronously. Release `btn` → no event.
